// File: rtl/adder32_rr_scheduler.sv
// Round-robin arbiter sharing one 32-bit adder among NREQ clients; result appears 2 cycles after accept, 3+ cycles per op.
// Backpressure: rsp_* held while rsp_ready=0, and no new request is accepted until the response is taken.

module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module adder32_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]    op_a_q, op_a_d;
    logic [31:0]    op_b_q, op_b_d;
    logic           op_cin_q, op_cin_d;
    logic [IDW-1:0] op_id_q, op_id_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   scan_idx;
    logic           req_hs;
    logic           rsp_hs;
    logic [31:0]    add_sum;
    logic           add_cout;

    // Rotating priority: scan from rr_ptr upward, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    adder32 u_adder (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .cin_i  (op_cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found)            state_d = EXEC;
            EXEC:                                state_d = RESP;
            RESP:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state_q != IDLE);
        req_hs    = 1'b0;
        rsp_hs    = 1'b0;
        if (rst_n && state_q == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
            req_hs    = 1'b1;
        end
        if (state_q == RESP && rsp_valid_q && rsp_ready) begin
            rsp_hs = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (req_hs) begin
            op_a_d   = req_a[32*grant_idx +: 32];
            op_b_d   = req_b[32*grant_idx +: 32];
            op_cin_d = req_cin[grant_idx];
            op_id_d  = grant_idx;
            rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
        end
        if (state_q == EXEC) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_id_q;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
        end
        // Payload fields keep their last value after the response is taken.
        if (rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder32_rr_scheduler.sv
// Bench for adder32_rr_scheduler: transaction-level reference model checked every cycle, plus directed literal cases.
module tb_adder32_rr_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_cin = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;
    logic                 busy;

    adder32_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] op_a [NREQ];
    logic [31:0] op_b [NREQ];
    logic [NREQ-1:0] op_cin;

    // Reference model: one outstanding transaction, result visible two edges after accept.
    bit          m_out = 0;
    bit          m_vld = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    logic [31:0] m_sum = '0;
    logic        m_cout = 1'b0;
    int          p_id = 0;
    logic [31:0] p_sum = '0;
    logic        p_cout = 1'b0;
    int          n_acc = 0;
    int          n_dut_rsp = 0;
    int          dropped = 0;
    int          acc_log[$];
    int          rsp_id_log[$];
    logic [32:0] rsp_val_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [NREQ-1:0] vld, input logic rrdy);
        int g;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_vld});
        chk("busy", {63'd0, busy}, {63'd0, m_out});
        chk("rsp_sum", {32'd0, rsp_sum}, {32'd0, m_sum});
        chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, m_cout});
        chk("rsp_id", {62'd0, rsp_id}, 64'(m_id));
        rst_n     = rst;
        req_valid = vld;
        rsp_ready = rrdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end
        req_cin = op_cin;
        #1;
        g = -1;
        if (rst && !m_out) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && vld[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        if (rst && rsp_valid && rrdy) begin
            n_dut_rsp++;
            rsp_id_log.push_back(int'(rsp_id));
            rsp_val_log.push_back({rsp_cout, rsp_sum});
        end
        if (!rst) begin
            if (m_out) dropped++;
            m_out = 0; m_vld = 0; m_ptr = 0;
            m_sum = '0; m_cout = 1'b0; m_id = 0;
        end else if (m_out) begin
            if (m_vld) begin
                if (rrdy) begin m_out = 0; m_vld = 0; end
            end else begin
                m_vld = 1; m_sum = p_sum; m_cout = p_cout; m_id = p_id;
            end
        end else if (g >= 0) begin
            {p_cout, p_sum} = {1'b0, op_a[g]} + {1'b0, op_b[g]} + 33'(op_cin[g]);
            p_id  = g;
            m_out = 1;
            m_ptr = (g + 1) % NREQ;
            n_acc++;
            acc_log.push_back(g);
        end
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            op_b[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        op_cin = NREQ'($urandom);
    endtask

    task automatic drain();
        repeat (4) step(1'b1, '0, 1'b1);
    endtask

    initial begin
        int target;
        int cyc;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
        op_cin = '0;

        // T1: reset held with all requesters valid
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        chk("t1_req_ready", {60'd0, req_ready}, 64'd0);
        chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd0);
        chk("t1_rsp_sum", {32'd0, rsp_sum}, 64'd0);

        // T2: single transaction with full wrap
        op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0001; op_cin = '0;
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        chk("t2_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
        step(1'b1, 4'b0000, 1'b1);
        chk("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("t2_sum", {32'd0, rsp_sum}, 64'h0);
        chk("t2_cout", {63'd0, rsp_cout}, 64'd1);
        chk("t2_id", {62'd0, rsp_id}, 64'd0);
        step(1'b1, 4'b0000, 1'b1);
        chk("t2_idle", {63'd0, busy}, 64'd0);

        // T3: round-robin from a fresh pointer
        step(1'b0, 4'b0000, 1'b1);
        acc_log.delete(); rsp_id_log.delete(); rsp_val_log.delete();
        for (int i = 0; i < NREQ; i++) begin op_a[i] = 32'(i); op_b[i] = 32'(i * 3); end
        op_a[2] = 32'h1234_5678; op_b[2] = 32'h8765_4321; op_cin = 4'b0100;
        repeat (15) step(1'b1, 4'hF, 1'b1);
        chk("t3_n_grants", 64'(acc_log.size()), 64'd5);
        if (acc_log.size() == 5) begin
            chk("t3_g0", 64'(acc_log[0]), 64'd0);
            chk("t3_g1", 64'(acc_log[1]), 64'd1);
            chk("t3_g2", 64'(acc_log[2]), 64'd2);
            chk("t3_g3", 64'(acc_log[3]), 64'd3);
            chk("t3_g4", 64'(acc_log[4]), 64'd0);
        end
        chk("t3_rsp_count", 64'(rsp_id_log.size() >= 3), 64'd1);
        if (rsp_id_log.size() >= 3) begin
            chk("t3_id2", 64'(rsp_id_log[2]), 64'd2);
            chk("t3_sum2", {31'd0, rsp_val_log[2]}, {31'd0, 1'b0, 32'h9999_999A});
        end
        drain();

        // T4: response backpressure
        op_a[1] = 32'h10; op_b[1] = 32'h20; op_cin = 4'b0010;
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("t4_hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t4_hold_sum", {32'd0, rsp_sum}, 64'h31);
            chk("t4_hold_id", {62'd0, rsp_id}, 64'd1);
            chk("t4_no_ready", {60'd0, req_ready}, 64'd0);
        end
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        chk("t4_idle_busy", {63'd0, busy}, 64'd0);
        chk("t4_idle_vld", {63'd0, rsp_valid}, 64'd0);

        // T5: reset during EXEC clears pointer and drops the request
        step(1'b1, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b1001, 1'b1);
        chk("t5_ptr_reset", 64'(acc_log[$]), 64'd0);
        drain();
        step(1'b1, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        op_a[3] = 32'hDEAD_0000; op_b[3] = 32'h0000_BEEF; op_cin = 4'b0000;
        step(1'b1, 4'b1000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        chk("t5_vld", {63'd0, rsp_valid}, 64'd1);
        chk("t5_id3", {62'd0, rsp_id}, 64'd3);
        chk("t5_sum", {32'd0, rsp_sum}, 64'hDEAD_BEEF);
        drain();

        // T6: random traffic
        target = n_acc + 1000;
        cyc = 0;
        while (n_acc < target && cyc < 40000) begin
            randomize_ops();
            step(($urandom_range(0, 399) != 0), NREQ'($urandom), ($urandom_range(0, 9) < 7));
            cyc++;
        end
        if (n_acc < target) chk("t6_timeout", 64'(n_acc), 64'(target));
        drain();
        chk("t6_no_loss", 64'(n_dut_rsp + dropped), 64'(n_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
